// File: rtl/s3_pkg.sv
// Shared definitions for S3 (ternary) polynomial packing and unpacking.
package s3_pkg;

   // 2-bit trit codes; 2'b11 is never produced
   localparam logic [1:0] TRIT_ZERO   = 2'b00;
   localparam logic [1:0] TRIT_ONE    = 2'b01;
   localparam logic [1:0] TRIT_MINUS1 = 2'b10;

   localparam int TRIT_BITS       = 2;
   localparam int TRITS_PER_BYTE  = 5;
   localparam int MAX_PACKED_BYTE = 242;   // 3^5 - 1

   // One decoded byte and one output beat (two bytes)
   localparam int BYTE_TRIT_BITS = TRIT_BITS * TRITS_PER_BYTE;
   localparam int BEAT_BITS      = 2 * BYTE_TRIT_BITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/bit8_to_trit5.sv
// Combinational base-3 decode of one packed byte into five 2-bit trit codes.
// Bytes above 242 cannot come from the packer; they decode to all-zero trits
// and raise the invalid flag.
module bit8_to_trit5
   import s3_pkg::*;
(
   input  logic [7:0]                byte_in,
   output logic [BYTE_TRIT_BITS-1:0] trits_out,
   output logic                      invalid
);

   // quot[i] is byte_in / 3^i; its remainder mod 3 is trit i
   logic [TRITS_PER_BYTE-1:0][7:0]  quot;
   logic [BYTE_TRIT_BITS-1:0]       raw_trits;

   assign quot[0] = byte_in;

   genvar gi;
   generate
      for (gi = 0; gi < TRITS_PER_BYTE; gi++) begin : g_digit
         logic [1:0] rem;
         assign rem = 2'(quot[gi] % 8'd3);
         assign raw_trits[gi*TRIT_BITS +: TRIT_BITS] =
            (rem == 2'd2) ? TRIT_MINUS1 :
            (rem == 2'd1) ? TRIT_ONE    : TRIT_ZERO;
         if (gi < TRITS_PER_BYTE - 1) begin : g_next
            assign quot[gi+1] = quot[gi] / 8'd3;
         end
      end
   endgenerate

   assign invalid   = (byte_in > 8'(MAX_PACKED_BYTE));
   assign trits_out = invalid ? '0 : raw_trits;

endmodule

// File: rtl/unpack_s3.sv
// Streams a packed S3 polynomial out as 20-bit beats of 10 trit codes.
// The whole packed vector is latched on start; beat 0 is decoded straight
// from the input so it is valid the cycle after start, later beats come
// from a shift register that drops 16 bits per loaded beat.
module unpack_s3
   import s3_pkg::*;
#(
   parameter int PACKED_BYTES = 140
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [8*PACKED_BYTES-1:0] packed_vec,
   output logic [BEAT_BITS-1:0]      trits,
   output logic                      valid,
   input  logic                      ready,
   output logic                      last,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int BEATS = PACKED_BYTES / 2;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VEC_W = 8 * PACKED_BYTES;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   state_t                 state_q, state_d;
   logic [VEC_W-1:0]       shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BEAT_BITS-1:0]   trits_q, trits_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic                   err_q, err_d;

   logic [15:0]               dec_in;
   logic [BYTE_TRIT_BITS-1:0] dec_trits [2];
   logic [1:0]                dec_inv;
   logic [BEAT_BITS-1:0]      dec_beat;
   logic [CNT_W-1:0]          cnt_inc;

   // In IDLE the first beat is taken directly from the input vector
   assign dec_in   = (state_q == ST_IDLE) ? packed_vec[15:0] : shift_q[15:0];
   assign dec_beat = {dec_trits[1], dec_trits[0]};
   assign cnt_inc  = cnt_q + CNT_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dec
         bit8_to_trit5 u_dec (
            .byte_in   (dec_in[gi*8 +: 8]),
            .trits_out (dec_trits[gi]),
            .invalid   (dec_inv[gi])
         );
      end
   endgenerate

   // Next-state, beat loading and error tracking
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      trits_d = trits_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               shift_d = packed_vec >> 16;
               cnt_d   = '0;
               trits_d = dec_beat;
               valid_d = 1'b1;
               last_d  = (LAST_CNT == '0);
               err_d   = |dec_inv;
            end
         end
         ST_RUN: begin
            if (!valid_q || ready) begin
               if (valid_q && last_q) begin
                  state_d = ST_FLUSH;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  shift_d = shift_q >> 16;
                  cnt_d   = cnt_inc;
                  trits_d = dec_beat;
                  valid_d = 1'b1;
                  last_d  = (cnt_inc == LAST_CNT);
                  err_d   = err_q | (|dec_inv);
               end
            end
         end
         ST_FLUSH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         trits_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         trits_q <= trits_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   assign trits = trits_q;
   assign valid = valid_q;
   assign last  = last_q;
   assign err   = err_q;
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_unpack_s3.sv
// Directed and model-based bench for unpack_s3 (140 packed bytes, 70 beats).
module tb_unpack_s3;

   localparam int PB = 140;
   localparam int NB = PB / 2;
   localparam int NT = PB * 5;

   logic            clk   = 1'b0;
   logic            rst   = 1'b0;
   logic            start = 1'b0;
   logic            ready = 1'b1;
   logic [8*PB-1:0] packed_vec = '0;
   logic [19:0]     trits;
   logic            valid, last, busy, done, err;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          trit_mem [NT];
   logic [19:0] exp_beat [NB];

   unpack_s3 #(.PACKED_BYTES(PB)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .packed_vec (packed_vec),
      .trits      (trits),
      .valid      (valid),
      .ready      (ready),
      .last       (last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " trits"}, trits, 0);
      check({tag, " valid"}, valid, 0);
      check({tag, " last"},  last,  0);
      check({tag, " busy"},  busy,  0);
      check({tag, " done"},  done,  0);
      check({tag, " err"},   err,   0);
   endtask

   // Reference packer: byte j = sum t(5j+i)*3^i; expected beats from raw trits
   task automatic pack_model();
      int b;
      int w;
      for (int j = 0; j < PB; j++) begin
         b = 0;
         w = 1;
         for (int i = 0; i < 5; i++) begin
            b += trit_mem[5*j+i] * w;
            w *= 3;
         end
         packed_vec[8*j +: 8] = 8'(b);
      end
      for (int k = 0; k < NB; k++)
         for (int i = 0; i < 10; i++)
            exp_beat[k][2*i +: 2] = 2'(trit_mem[10*k+i]);
   endtask

   task automatic random_trits();
      for (int i = 0; i < NT; i++) trit_mem[i] = int'($urandom_range(0, 2));
   endtask

   // One unpack: start, collect NB beats, check handshake, timing and done
   task automatic run_stream(input string name, input bit bp, input bit timing,
                             input bit poke_start, input bit exp_err);
      int          got;
      int          cyc;
      bit          stalled;
      logic [19:0] prev_trits;
      logic        prev_last;
      logic [8*PB-1:0] saved;
      got = 0;
      cyc = 1;
      stalled = 1'b0;
      prev_trits = '0;
      prev_last = 1'b0;
      saved = packed_vec;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (got < NB && cyc < 400) begin
         check("valid", valid, 1);
         check("busy", busy, 1);
         if (cyc == 1) check("err cleared", err, 0);
         if (stalled) begin
            check("hold trits", trits, prev_trits);
            check("hold last", last, prev_last);
         end
         if (poke_start && cyc >= 10 && cyc < 13) begin
            start = 1'b1;
            packed_vec = ~saved;
         end else begin
            start = 1'b0;
         end
         ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (valid && ready) begin
            check("beat trits", trits, exp_beat[got]);
            check("beat last", last, (got == NB - 1));
            if (timing) check("beat cycle", cyc, got + 1);
            got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            prev_trits = trits;
            prev_last = last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      packed_vec = saved;
      ready = 1'b1;
      check("beat count", got, NB);
      check("done pulse", done, 1);
      check("busy at done", busy, 0);
      check("valid at done", valid, 0);
      check("last at done", last, 0);
      check("err at done", err, exp_err);
      if (timing) check("done cycle", cyc, NB + 1);
      @(posedge clk); #1;
      check("done width", done, 0);
      check("busy idle", busy, 0);
      check("err idle", err, exp_err);
      $display("stream %s: %0d beats, done at cycle %0d, err=%0b", name, got, cyc, err);
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed: bytes 0x00,0xF2 -> low half 0, high half all 2'b10 = 20'hAA800
      packed_vec = '0;
      packed_vec[15:8] = 8'hF2;
      for (int k = 0; k < NB; k++) exp_beat[k] = '0;
      exp_beat[0] = 20'hAA800;
      run_stream("bytes_00_f2", 1'b0, 1'b1, 1'b0, 1'b0);

      // Directed: bytes 0x05,0x01 -> t0=2,t1=1,t5=1 = 20'h00406
      packed_vec = '0;
      packed_vec[7:0]  = 8'h05;
      packed_vec[15:8] = 8'h01;
      for (int k = 0; k < NB; k++) exp_beat[k] = '0;
      exp_beat[0] = 20'h00406;
      run_stream("bytes_05_01", 1'b0, 1'b1, 1'b0, 1'b0);

      // Full random stream, ready held high
      random_trits();
      pack_model();
      run_stream("full_ready", 1'b0, 1'b1, 1'b0, 1'b0);

      // Backpressure
      random_trits();
      pack_model();
      run_stream("backpressure", 1'b1, 1'b0, 1'b0, 1'b0);

      // Invalid byte 7 (high byte of beat 3)
      random_trits();
      pack_model();
      packed_vec[8*7 +: 8] = 8'hF3;
      exp_beat[3][19:10] = '0;
      run_stream("invalid_byte", 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("err sticky", err, 1);

      // Round trip with backpressure and start pulses while busy
      random_trits();
      pack_model();
      run_stream("round_trip", 1'b1, 1'b0, 1'b1, 1'b0);

      // Mid-stream asynchronous reset
      random_trits();
      pack_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre-reset valid", valid, 1);
      rst = 1'b0;
      #1;
      check_idle_outputs("async rst");
      @(posedge clk); #1;
      check_idle_outputs("in rst");
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post-rst done", done, 0);
         check("post-rst valid", valid, 0);
         check("post-rst busy", busy, 0);
      end
      $display("stream mid_reset: aborted after 5 cycles");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
